fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of instruction_register.
//  - Owns the program counter and issues one-at-a-time requests to the instruction memory.
//  - Presents each returned word on instruction_out with a one-cycle ir_load_en pulse;
//    these drive instruction_register's instruction_in and load_en.
//  - Supports decode stall and taken-branch redirect; discards in-flight fetches on redirect.
// PARAMETERS
//  ADDR_W    8       PC / instruction-memory address width (word addressed)
//  INSTR_W   16      instruction width; matches instruction_register
//  RESET_PC  0       PC value loaded on reset
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        synchronous, active-high
//  stall           in   1        downstream not ready; hold the next delivery
//  branch_taken    in   1        one-cycle redirect request
//  branch_target   in   ADDR_W   new PC when branch_taken=1
//  imem_req        out  1        fetch request; combinational, (state==ISSUE && !branch_taken && !reset)
//  imem_addr       out  ADDR_W   address of the request; equals pc
//  imem_rdata      in   INSTR_W  memory read data; qualified by imem_valid
//  imem_valid      in   1        response strobe; arrives >=1 cycle after imem_req, max 1 outstanding
//  instruction_out out  INSTR_W  fetched word to instruction_register.instruction_in (registered)
//  ir_load_en      out  1        one-cycle pulse: instruction_out is new (registered)
//  fetch_pc        out  ADDR_W   address of the word on instruction_out (registered)
//  pc_out          out  ADDR_W   current PC (next address to fetch)
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=ISSUE, instruction_out=0, ir_load_en=0, fetch_pc=0, hold_buf=0.
//  ir_load_en defaults to 0 every cycle; it is set only by a delivery.
//  FSM states: ISSUE, WAIT, HOLD, DRAIN.
//  - ISSUE: imem_req=1, then go to WAIT. If branch_taken: no request, pc<=branch_target, stay in ISSUE.
//  - WAIT, imem_valid && !stall: deliver, pc<=pc+1, go to ISSUE.
//  - WAIT, imem_valid && stall: hold_buf<=imem_rdata, go to HOLD.
//  - HOLD, !stall: deliver hold_buf, pc<=pc+1, go to ISSUE.
//  - DRAIN: wait for imem_valid, discard the data, go to ISSUE. pc is already redirected.
//  Deliver: instruction_out<=word, fetch_pc<=pc, ir_load_en<=1 on the next edge.
//  Latency: ISSUE to ir_load_en is (memory latency + 1) cycles; 1-cycle memory gives 1 instr / 2 cycles.
//  Branch in WAIT, imem_valid=0: pc<=target, go to DRAIN.
//  Branch in WAIT, imem_valid=1: discard the response, pc<=target, go to ISSUE.
//  Branch in HOLD: discard hold_buf, pc<=target, go to ISSUE.
//  Branch in DRAIN: pc<=target, stay in DRAIN.
//  Priority: branch_taken beats stall and beats delivery; a redirected word is never delivered.
//  Stall does not block an in-flight memory response; the word is buffered.
//  Stall asserted in ISSUE still issues the request (prefetch one word).
//  Arithmetic: pc+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
//  imem_valid outside WAIT/DRAIN is ignored, e.g. a late response after reset.
//  reset mid-operation: all state returns to reset values at the next edge.
//  The memory model must also drop an outstanding request on reset.
// STRUCTURE
//  cpu_pkg holds:
//  - FSM state encoding (2-bit localparams ISSUE/WAIT/HOLD/DRAIN)
//  - default ADDR_W / INSTR_W
//  - RESET_PC default
//  One sub-module: pc_reg. Inputs: reset, load (branch), inc (delivery), target.
//  Priority inside pc_reg: reset > load > inc. The FSM and output registers stay in fetch_unit.
// TESTING  (1-cycle memory model unless noted; mem[a]=16'hA000+a)
//  1. Reset 2 cycles, release.
//     -> imem_req=1, imem_addr=0; instruction_out=A000, A001, A002 with ir_load_en
//        pulses 2 cycles apart; fetch_pc=0,1,2.
//  2. Assert stall the cycle imem_valid returns addr 3, hold 3 cycles.
//     -> ir_load_en stays 0 while stalled; then one pulse with A003;
//        pc_out=4 after; no duplicate delivery.
//  3. 3-cycle memory. branch_taken=1, target=8'h40, 1 cycle after a request to addr 5.
//     -> addr 5 data discarded in DRAIN; next imem_addr=40; next delivery is A040, fetch_pc=40.
//  4. branch_taken in ISSUE with target=8'h10, and branch_taken together with imem_valid in WAIT.
//     -> no request that cycle / response dropped; next delivery is A010.
//  5. Wrap: branch to 8'hFF, fetch two words.
//     -> deliveries AOFF then A000 (wrapped), fetch_pc=FF then 00; pc_out=01.
//  6. Assert reset while in WAIT with 3-cycle memory.
//     -> next edge: pc_out=0, ir_load_en=0, instruction_out=0;
//        late imem_valid ignored; fetch restarts at addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: default widths, reset PC and FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: reset > load (redirect) > inc (delivery); increment wraps modulo 2^ADDR_W.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)     pc <= RESET_PC;
    else if (load) pc <= target;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues one request at a time, buffers a stalled response and
// handles branch redirects, delivering words to the instruction register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               ir_load_en,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic [ADDR_W-1:0]  pc_out
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] hold_buf;
  logic [ADDR_W-1:0]  pc;
  logic               deliver_wait;
  logic               deliver_hold;

  always_comb begin
    deliver_wait = 1'b0;
    deliver_hold = 1'b0;
    if (!branch_taken && !stall) begin
      deliver_wait = (state == WAIT) && imem.imem_valid;
      deliver_hold = (state == HOLD);
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (branch_taken),
    .inc    (deliver_wait | deliver_hold),
    .target (branch_target),
    .pc     (pc)
  );

  assign imem.imem_req  = (state == ISSUE) && !branch_taken && !reset;
  assign imem.imem_addr = pc;
  assign pc_out         = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ISSUE;
      instruction_out <= '0;
      ir_load_en      <= 1'b0;
      fetch_pc        <= '0;
      hold_buf        <= '0;
    end else begin
      ir_load_en <= 1'b0;
      case (state)
        ISSUE: if (!branch_taken) state <= WAIT;
        WAIT: begin
          if (branch_taken) begin
            state <= imem.imem_valid ? ISSUE : DRAIN;
          end else if (imem.imem_valid) begin
            if (!stall) begin
              instruction_out <= imem.imem_rdata;
              fetch_pc        <= pc;
              ir_load_en      <= 1'b1;
              state           <= ISSUE;
            end else begin
              hold_buf <= imem.imem_rdata;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            state <= ISSUE;
          end else if (!stall) begin
            instruction_out <= hold_buf;
            fetch_pc        <= pc;
            ir_load_en      <= 1'b1;
            state           <= ISSUE;
          end
        end
        // The discarded response always ends the drain, even alongside a further
        // redirect: no second response will follow, so staying would deadlock.
        DRAIN: if (imem.imem_valid) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a PC-sequence reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [15:0] instruction_out;
  logic        ir_load_en;
  logic [7:0]  fetch_pc;
  logic [7:0]  pc_out;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem            (bus),
    .instruction_out (instruction_out),
    .ir_load_en      (ir_load_en),
    .fetch_pc        (fetch_pc),
    .pc_out          (pc_out)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = A000+a, fixed latency, one outstanding, dropped on reset.
  int unsigned lat = 1;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy = 1'b0;
  int unsigned cnt = 0;
  logic [7:0]  addr_q = '0;
  logic        stray = 1'b0;

  assign bus.imem_valid = mem_valid | stray;
  assign bus.imem_rdata = stray ? 16'hDEAD : mem_rdata;

  always @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          mem_valid <= 1'b1;
          mem_rdata <= 16'hA000 + {8'h00, addr_q};
          busy      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req) begin
        if (lat == 1) begin
          mem_valid <= 1'b1;
          mem_rdata <= 16'hA000 + {8'h00, bus.imem_addr};
        end else begin
          busy   <= 1'b1;
          addr_q <= bus.imem_addr;
          cnt    <= lat - 1;
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_pc = '0;
  int          deliveries = 0;
  int          cycle = 0;
  int          last_pulse = -1;
  int          last_gap = 0;
  logic [7:0]  last_fetch = '0;
  logic [15:0] last_instr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then check outputs against the model.
  task automatic step(input logic st, input logic br, input logic [7:0] tgt, input logic rs);
    stall = st; branch_taken = br; branch_target = tgt; reset = rs;
    @(posedge clk); #1;
    cycle++;
    if (rs) begin
      exp_pc = 8'h00;
      last_pulse = -1;
      chk("rst_load_en", {31'd0, ir_load_en}, 32'd0);
      chk("rst_instr", {16'd0, instruction_out}, 32'd0);
      chk("rst_fetch_pc", {24'd0, fetch_pc}, 32'd0);
    end else if (br) begin
      chk("branch_no_delivery", {31'd0, ir_load_en}, 32'd0);
      exp_pc = tgt;
    end else begin
      if (st) chk("stall_no_delivery", {31'd0, ir_load_en}, 32'd0);
      if (ir_load_en === 1'b1) begin
        chk("deliv_fetch_pc", {24'd0, fetch_pc}, {24'd0, exp_pc});
        chk("deliv_instr", {16'd0, instruction_out}, 32'hA000 + {24'd0, exp_pc});
        if (last_pulse >= 0) last_gap = cycle - last_pulse;
        last_pulse = cycle;
        last_fetch = fetch_pc;
        last_instr = instruction_out;
        deliveries++;
        exp_pc = exp_pc + 8'd1;
      end
    end
    chk("pc_out", {24'd0, pc_out}, {24'd0, exp_pc});
    if (bus.imem_req === 1'b1) chk("req_addr", {24'd0, bus.imem_addr}, {24'd0, exp_pc});
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (deliveries < target && k < budget) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("delivery_timeout", {31'd0, deliveries >= target}, 32'd1);
  endtask

  initial begin
    int d0;
    // 1: reset, then three deliveries two cycles apart
    lat = 1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    #1;
    chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_addr", {24'd0, bus.imem_addr}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_count", deliveries, 32'd3);
    chk("t1_gap", last_gap, 32'd2);
    chk("t1_last_pc", {24'd0, last_fetch}, 32'd2);

    // 2: stall as the addr-3 response returns
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_count", deliveries, 32'd4);
    chk("t2_instr", {16'd0, last_instr}, 32'hA003);
    chk("t2_pc_out", {24'd0, pc_out}, 32'd4);

    // 3: 3-cycle memory, redirect while addr 5 is in flight
    lat = 3;
    run_until(5, 20);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    chk("t3_drain_no_req", {31'd0, bus.imem_req}, 32'd0);
    run_until(6, 30);
    chk("t3_fetch_pc", {24'd0, last_fetch}, 32'h40);
    chk("t3_instr", {16'd0, last_instr}, 32'hA040);

    // 4: redirect in ISSUE, then redirect coinciding with a response
    lat = 1;
    stall = 1'b0; branch_taken = 1'b1; branch_target = 8'h10;
    #1;
    chk("t4_issue_no_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_valid_in_wait", {31'd0, bus.imem_valid}, 32'd1);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    run_until(deliveries + 1, 10);
    chk("t4_instr", {16'd0, last_instr}, 32'hA010);

    // 5: wrap past FF
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    d0 = deliveries;
    run_until(d0 + 1, 10);
    chk("t5_fetch_ff", {24'd0, last_fetch}, 32'hFF);
    chk("t5_instr_ff", {16'd0, last_instr}, 32'hA0FF);
    run_until(d0 + 2, 10);
    chk("t5_fetch_00", {24'd0, last_fetch}, 32'h00);
    chk("t5_instr_00", {16'd0, last_instr}, 32'hA000);
    chk("t5_pc_out", {24'd0, pc_out}, 32'h01);

    // 6: reset while waiting on a 3-cycle response, stray strobe afterwards
    lat = 3;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_pc_out", {24'd0, pc_out}, 32'd0);
    reset = 1'b0;
    stray = 1'b1;
    #1;
    chk("t6_req_addr0", {31'd0, bus.imem_req}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    stray = 1'b0;
    d0 = deliveries;
    run_until(d0 + 1, 20);
    chk("t6_fetch_pc", {24'd0, last_fetch}, 32'd0);
    chk("t6_instr", {16'd0, last_instr}, 32'hA000);

    // Randomized stall/redirect traffic at each memory latency
    for (int ep = 1; ep <= 3; ep++) begin
      lat = ep;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      d0 = deliveries;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
             8'($urandom_range(0, 255)), 1'b0);
      end
      chk("rand_progress", {31'd0, deliveries > d0}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
